// File: rtl/axi_xbar_map_ctrl_pkg.sv
// Shared types for the crossbar address-map controller.
//   rule_t : one address-map rule {idx, start_addr, end_addr}
//   req_t  : slave-port request bundle (AW, W, B-ready, AR, R-ready)
//   resp_t : slave-port response bundle (AW/AR/W ready, B, R)
//   idx_width() : width of a rule index for a given rule count
package axi_xbar_map_ctrl_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } rule_t;

    typedef struct packed {
        logic [5:0]  aw_id;
        logic [63:0] aw_addr;
        logic [7:0]  aw_len;
        logic        aw_valid;
        logic [63:0] w_data;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [5:0]  ar_id;
        logic [63:0] ar_addr;
        logic [7:0]  ar_len;
        logic        ar_valid;
        logic        r_ready;
    } req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic [5:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic [5:0]  r_id;
        logic [63:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
    } resp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_xbar_map_ctrl_port.sv
// Per-slave-port transaction tracker and AW/AR gate.
//   clk_i, rst_ni  : clock, async active-low reset
//   block_i        : controller requests that new AW/AR be held off
//   slv_req_i/slv_resp_o   : upstream side
//   xbar_req_o/xbar_resp_i : crossbar side
//   idle_o         : no outstanding reads/writes and no pending AW/AR
module axi_xbar_map_ctrl_port
    import axi_xbar_map_ctrl_pkg::*;
#(
    parameter int unsigned MaxTxns = 8
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  block_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  xbar_req_o,
    input  resp_t xbar_resp_i,
    output logic  idle_o
);

    localparam int unsigned CntW = $clog2(MaxTxns + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

    logic [CntW-1:0] wr_cnt, rd_cnt;
    logic            aw_pend, ar_pend;
    logic            aw_gate, ar_gate;
    logic            aw_hs, ar_hs, b_hs, rlast_hs;

    // A channel whose valid is already presented to the crossbar is never
    // gated, so valid stays stable until the handshake completes.
    assign aw_gate = ~aw_pend & (block_i | (wr_cnt == CntMax));
    assign ar_gate = ~ar_pend & (block_i | (rd_cnt == CntMax));

    always_comb begin
        xbar_req_o          = slv_req_i;
        xbar_req_o.aw_valid = slv_req_i.aw_valid & ~aw_gate;
        xbar_req_o.ar_valid = slv_req_i.ar_valid & ~ar_gate;
        slv_resp_o          = xbar_resp_i;
        slv_resp_o.aw_ready = xbar_resp_i.aw_ready & ~aw_gate;
        slv_resp_o.ar_ready = xbar_resp_i.ar_ready & ~ar_gate;
    end

    assign aw_hs    = xbar_req_o.aw_valid & xbar_resp_i.aw_ready;
    assign ar_hs    = xbar_req_o.ar_valid & xbar_resp_i.ar_ready;
    assign b_hs     = xbar_resp_i.b_valid & slv_req_i.b_ready;
    assign rlast_hs = xbar_resp_i.r_valid & slv_req_i.r_ready & xbar_resp_i.r_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            aw_pend <= 1'b0;
            ar_pend <= 1'b0;
        end else begin
            if (aw_hs && !b_hs)
                wr_cnt <= wr_cnt + 1'b1;
            else if (!aw_hs && b_hs)
                wr_cnt <= wr_cnt - 1'b1;
            if (ar_hs && !rlast_hs)
                rd_cnt <= rd_cnt + 1'b1;
            else if (!ar_hs && rlast_hs)
                rd_cnt <= rd_cnt - 1'b1;
            aw_pend <= xbar_req_o.aw_valid & ~xbar_resp_i.aw_ready;
            ar_pend <= xbar_req_o.ar_valid & ~xbar_resp_i.ar_ready;
        end
    end

    assign idle_o = (wr_cnt == '0) & (rd_cnt == '0) & ~aw_pend & ~ar_pend;

endmodule

// File: rtl/axi_xbar_map_ctrl.sv
// Run-time address-map controller for the AXI crossbar.
// Holds a shadow map written through a config port and copies it into the
// active map only after every slave port has drained.
//   clk_i, rst_ni               : clock, async active-low reset
//   slv_reqs_i/slv_resps_o      : upstream side of each slave port
//   xbar_reqs_o/xbar_resps_i    : crossbar side of each slave port
//   cfg_req_i/cfg_gnt_o/cfg_idx_i/cfg_rule_i : shadow rule write
//   cfg_commit_i                : request shadow-to-active swap
//   addr_map_o                  : active map to the crossbar
//   busy_o, commit_done_o       : status
module axi_xbar_map_ctrl
    import axi_xbar_map_ctrl_pkg::*;
#(
    parameter int unsigned NoSlvPorts  = 1,
    parameter int unsigned NoAddrRules = 1,
    parameter int unsigned MaxTxns     = 8,
    parameter rule_t [NoAddrRules-1:0] ResetMap = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  req_t  [NoSlvPorts-1:0]               slv_reqs_i,
    output resp_t [NoSlvPorts-1:0]               slv_resps_o,
    output req_t  [NoSlvPorts-1:0]               xbar_reqs_o,
    input  resp_t [NoSlvPorts-1:0]               xbar_resps_i,
    input  logic                                 cfg_req_i,
    output logic                                 cfg_gnt_o,
    input  logic [idx_width(NoAddrRules)-1:0]    cfg_idx_i,
    input  rule_t                                cfg_rule_i,
    input  logic                                 cfg_commit_i,
    output rule_t [NoAddrRules-1:0]              addr_map_o,
    output logic                                 busy_o,
    output logic                                 commit_done_o
);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;

    state_e                  state, state_next;
    rule_t [NoAddrRules-1:0] shadow, active;
    logic  [NoSlvPorts-1:0]  port_idle;
    logic                    block;
    logic                    idx_ok;

    assign block = (state != IDLE);

    for (genvar p = 0; p < NoSlvPorts; p++) begin : g_port
        axi_xbar_map_ctrl_port #(
            .MaxTxns(MaxTxns)
        ) u_port (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .block_i    (block),
            .slv_req_i  (slv_reqs_i[p]),
            .slv_resp_o (slv_resps_o[p]),
            .xbar_req_o (xbar_reqs_o[p]),
            .xbar_resp_i(xbar_resps_i[p]),
            .idle_o     (port_idle[p])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_commit_i) state_next = DRAIN;
            DRAIN:   if (&port_idle) state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes are accepted only in IDLE; an index beyond the map is granted
    // but has no effect.
    assign cfg_gnt_o     = cfg_req_i & (state == IDLE);
    assign idx_ok        = 32'(cfg_idx_i) < NoAddrRules;
    assign busy_o        = (state != IDLE);
    assign commit_done_o = (state == SWAP);
    assign addr_map_o    = active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            shadow <= ResetMap;
            active <= ResetMap;
        end else begin
            state <= state_next;
            if (cfg_gnt_o && idx_ok)
                shadow[cfg_idx_i] <= cfg_rule_i;
            if (state == SWAP)
                active <= shadow;
        end
    end

endmodule
